// File: rtl/tile_pkg.sv
// Shared definitions for the tile drawing controller.
//   TILE_SIZE     default tile edge length in pixels (power of two, 2..16)
//   tile_state_e  controller FSM state encoding
//   BLACK, WHITE, TILEn_COLOUR  3-bit VGA colour constants
package tile_pkg;

  localparam int unsigned TILE_SIZE = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDraw,
    StDone
  } tile_state_e;

  localparam logic [2:0] BLACK        = 3'b000;
  localparam logic [2:0] WHITE        = 3'b111;
  localparam logic [2:0] TILE0_COLOUR = 3'b001;
  localparam logic [2:0] TILE1_COLOUR = 3'b010;
  localparam logic [2:0] TILE2_COLOUR = 3'b011;
  localparam logic [2:0] TILE3_COLOUR = 3'b100;

endpackage

// File: rtl/tile_origin_lut.sv
// Combinational map from a 2-bit tile index to its screen origin and fill colour.
// Tiles form a 2x2 grid: index bit 0 selects the column, bit 1 the row.
// Ports:
//   tile_i         tile index 0..3
//   origin_x_o     pixel column of the tile's top-left corner
//   origin_y_o     pixel row of the tile's top-left corner
//   tile_colour_o  fill colour of the tile
module tile_origin_lut #(
  parameter int unsigned TILE_SIZE = tile_pkg::TILE_SIZE
) (
  input  logic [1:0] tile_i,
  output logic [7:0] origin_x_o,
  output logic [6:0] origin_y_o,
  output logic [2:0] tile_colour_o
);
  import tile_pkg::*;

  localparam logic [7:0] StepX = 8'(TILE_SIZE);
  localparam logic [6:0] StepY = 7'(TILE_SIZE);

  always_comb begin
    origin_x_o    = '0;
    origin_y_o    = '0;
    tile_colour_o = BLACK;
    unique case (tile_i)
      2'd0: begin
        tile_colour_o = TILE0_COLOUR;
      end
      2'd1: begin
        origin_x_o    = StepX;
        tile_colour_o = TILE1_COLOUR;
      end
      2'd2: begin
        origin_y_o    = StepY;
        tile_colour_o = TILE2_COLOUR;
      end
      2'd3: begin
        origin_x_o    = StepX;
        origin_y_o    = StepY;
        tile_colour_o = TILE3_COLOUR;
      end
    endcase
  end

endmodule

// File: rtl/tile_draw_ctrl.sv
// Tile draw controller: on an accepted start, plots one TILE_SIZE x TILE_SIZE tile
// row-major into a VGA adapter, one pixel per cycle, then pulses done.
// Optional build macro TILE_BORDER_EN: non-erase draws paint the tile's outer
// ring white; cycle timing is unchanged.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   start          draw request, sampled only while ready=1
//   tile, erase    tile index and erase flag, sampled with start
//   ready          idle, will accept start
//   x, y, colour   registered pixel coordinates and colour, held while plot=0
//   plot           pixel write strobe
//   done           one-cycle pulse when a tile draw completes
module tile_draw_ctrl #(
  parameter int unsigned TILE_SIZE = tile_pkg::TILE_SIZE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] tile,
  input  logic       erase,
  output logic       ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);
  import tile_pkg::*;

  localparam int unsigned    CntW   = $clog2(TILE_SIZE);
  localparam logic [CntW-1:0] CntMax = CntW'(TILE_SIZE - 1);

`ifdef TILE_BORDER_EN
  localparam bit BorderEn = 1'b1;
`else
  localparam bit BorderEn = 1'b0;
`endif

  function automatic logic [2:0] pixel_colour(input logic [2:0]      tcol,
                                              input logic            ers,
                                              input logic [CntW-1:0] lx,
                                              input logic [CntW-1:0] ly);
    logic on_edge;
    on_edge = (lx == '0) || (lx == CntMax) || (ly == '0) || (ly == CntMax);
    if (ers) return BLACK;
    if (BorderEn && on_edge) return WHITE;
    return tcol;
  endfunction

  tile_state_e state_q, state_d;

  // Request captured at acceptance so later input changes are ignored.
  logic [1:0] tile_q;
  logic       erase_req_q;

  // Draw context registered in LOAD.
  logic [7:0] org_x_q;
  logic [6:0] org_y_q;
  logic [2:0] tcol_q;
  logic       erase_q;

  // Local coordinates of the pixel currently on the outputs.
  logic [CntW-1:0] lx_q, ly_q;
  logic [CntW-1:0] lx_nxt, ly_nxt;

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;

  logic [7:0] lut_x;
  logic [6:0] lut_y;
  logic [2:0] lut_col;

  logic            last_pix;
  logic [7:0]      src_ox;
  logic [6:0]      src_oy;
  logic [2:0]      src_col;
  logic            src_erase;
  logic [CntW-1:0] src_lx, src_ly;

  tile_origin_lut #(
    .TILE_SIZE(TILE_SIZE)
  ) u_lut (
    .tile_i       (tile_q),
    .origin_x_o   (lut_x),
    .origin_y_o   (lut_y),
    .tile_colour_o(lut_col)
  );

  always_comb begin
    state_d  = state_q;
    last_pix = (lx_q == CntMax) && (ly_q == CntMax);
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StDraw;
      StDraw:  if (last_pix) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Row-major scan step.
  always_comb begin
    lx_nxt = lx_q;
    ly_nxt = ly_q;
    if (lx_q == CntMax) begin
      lx_nxt = '0;
      ly_nxt = ly_q + 1'b1;
    end else begin
      lx_nxt = lx_q + 1'b1;
    end
  end

  // Pixel registers are loaded one edge ahead of plot: from the LUT for the first
  // pixel (leaving LOAD), from the registered context for every later pixel.
  always_comb begin
    src_ox    = org_x_q;
    src_oy    = org_y_q;
    src_col   = tcol_q;
    src_erase = erase_q;
    src_lx    = lx_nxt;
    src_ly    = ly_nxt;
    if (state_q == StLoad) begin
      src_ox    = lut_x;
      src_oy    = lut_y;
      src_col   = lut_col;
      src_erase = erase_req_q;
      src_lx    = '0;
      src_ly    = '0;
    end
    x_d      = src_ox + 8'(src_lx);
    y_d      = src_oy + 7'(src_ly);
    colour_d = pixel_colour(src_col, src_erase, src_lx, src_ly);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      tile_q      <= '0;
      erase_req_q <= 1'b0;
      org_x_q     <= '0;
      org_y_q     <= '0;
      tcol_q      <= BLACK;
      erase_q     <= 1'b0;
      lx_q        <= '0;
      ly_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= BLACK;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && start) begin
        tile_q      <= tile;
        erase_req_q <= erase;
      end
      if (state_q == StLoad) begin
        org_x_q  <= lut_x;
        org_y_q  <= lut_y;
        tcol_q   <= lut_col;
        erase_q  <= erase_req_q;
        lx_q     <= '0;
        ly_q     <= '0;
        x_q      <= x_d;
        y_q      <= y_d;
        colour_q <= colour_d;
      end
      if ((state_q == StDraw) && !last_pix) begin
        lx_q     <= lx_nxt;
        ly_q     <= ly_nxt;
        x_q      <= x_d;
        y_q      <= y_d;
        colour_q <= colour_d;
      end
    end
  end

  assign ready  = (state_q == StIdle);
  assign plot   = (state_q == StDraw);
  assign done   = (state_q == StDone);
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_tile_draw_ctrl.sv
// Scoreboard bench for tile_draw_ctrl: the driver pushes the expected pixel stream
// and done cycle of each accepted request; a negedge monitor pops and compares.
module tb_tile_draw_ctrl;

  localparam int TS = 8;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] tile;
  logic       erase;
  logic       ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   chk_en = 1'b0;
  pix_t pix_q[$];
  int   done_q[$];
  pix_t last_px = '0;

  tile_draw_ctrl #(
    .TILE_SIZE(TS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .tile  (tile),
    .erase (erase),
    .ready (ready),
    .x     (x),
    .y     (y),
    .colour(colour),
    .plot  (plot),
    .done  (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the full pixel list of a tile, from the mapping rules.
  function automatic void push_req(input int t, input int e, input int acc);
    int ox, oy;
    logic [2:0] c;
    ox = (t % 2) * TS;
    oy = (t / 2) * TS;
    for (int py = 0; py < TS; py++) begin
      for (int px = 0; px < TS; px++) begin
        c = (e != 0) ? 3'd0 : 3'(t + 1);
`ifdef TILE_BORDER_EN
        if (e == 0 && (px == 0 || px == TS - 1 || py == 0 || py == TS - 1)) c = 3'b111;
`endif
        pix_q.push_back('{x: 8'(ox + px), y: 7'(oy + py), c: c});
      end
    end
    done_q.push_back(acc + TS * TS + 2);
  endfunction

  function automatic void flush();
    pix_q.delete();
    done_q.delete();
    last_px = '0;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      if (plot) begin
        if (pix_q.size() == 0) begin
          check("plot_unexpected", {14'b0, x, y, colour}, 32'h3ffff);
        end else begin
          pix_t e;
          e = pix_q.pop_front();
          check("pixel", {14'b0, x, y, colour}, {14'b0, e});
          last_px = e;
        end
      end else begin
        check("hold_xyc", {14'b0, x, y, colour}, {14'b0, last_px});
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
          check("pixels_left_at_done", 32'(pix_q.size()), 32'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // noise: 0 quiet, 1 random start/tile/erase during the draw, 2 start with tile 2 held.
  task automatic draw(input int t, input int e, input int noise);
    int k;
    k = 0;
    while (!ready && k < 200) begin
      step();
      k++;
    end
    check("ready_before_start", 32'(ready), 32'd1);
    if (!ready) return;
    push_req(t, e, cyc);
    start = 1'b1;
    tile  = 2'(t);
    erase = e[0];
    step();
    start = 1'b0;
    k = 0;
    while (!done && k < TS * TS + 20) begin
      if (noise == 1) begin
        start = 1'($urandom_range(0, 1));
        tile  = 2'($urandom_range(0, 3));
        erase = 1'($urandom_range(0, 1));
      end else if (noise == 2) begin
        start = 1'b1;
        tile  = 2'd2;
        erase = 1'b1;
      end
      step();
      k++;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    if (!done) begin
      flush();
      return;
    end
    step();
    check("ready_after_done", 32'(ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    tile  = 2'd0;
    erase = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_xyc", {14'b0, x, y, colour}, 32'd0);
    last_px = '0;
    chk_en  = 1'b1;
    step();

    draw(0, 0, 0);
    draw(3, 0, 0);
    draw(1, 1, 0);
    draw(1, 0, 2);
    draw(2, 0, 0);

    // Reset in the cycle showing pixel 20 aborts the draw without done.
    push_req(0, 0, cyc);
    start = 1'b1;
    tile  = 2'd0;
    erase = 1'b0;
    step();
    start = 1'b0;
    repeat (21) step();
    check("plot_before_abort", 32'(plot), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    flush();
    check("abort_plot", 32'(plot), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_xyc", {14'b0, x, y, colour}, 32'd0);
    repeat (3) begin
      step();
      check("abort_idle_ready", 32'(ready), 32'd1);
    end
    draw(0, 0, 0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    reset = 1'b1;
    tile  = 2'd3;
    step();
    start = 1'b0;
    reset = 1'b0;
    last_px = '0;
    check("rst_vs_start_ready", 32'(ready), 32'd1);
    step();
    check("rst_vs_start_idle", 32'(ready), 32'd1);
    check("rst_vs_start_plot", 32'(plot), 32'd0);

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) step();
      draw(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1);
    end

    repeat (3) step();
    check("queue_empty_end", 32'(pix_q.size() + done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tile_draw_ctrl.md
TILE_DRAW_CTRL -- requirements
Module: tile_draw_ctrl

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 8, meaning tile edge length in pixels; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: draw request, sampled only while ready=1.
REQ-005 SHALL have port tile, input, 2 bits: tile index 0..3, sampled with start.
REQ-006 SHALL have port erase, input, 1 bit: when 1, draw the tile in black (3'b000); sampled with start.
REQ-007 SHALL have port ready, output, 1 bit: block is idle and will accept start.
REQ-008 SHALL have port x, output, 8 bits: pixel column to the VGA adapter.
REQ-009 SHALL have port y, output, 7 bits: pixel row to the VGA adapter.
REQ-010 SHALL have port colour, output, 3 bits: pixel colour to the VGA adapter.
REQ-011 SHALL have port plot, output, 1 bit: writes the pixel at x, y, colour this cycle.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a tile draw completes.

Function
REQ-013 SHALL use tile-to-origin/colour mapping: tile 0 at (0,0) colour 001; tile 1 at (TILE_SIZE,0) colour 010; tile 2 at (0,TILE_SIZE) colour 011; tile 3 at (TILE_SIZE,TILE_SIZE) colour 100.
REQ-014 SHALL implement FSM states IDLE, LOAD, DRAW, DONE.
REQ-015 SHALL transition IDLE->LOAD on start=1; in IDLE, ready=1 and plot=0.
REQ-016 SHALL, in LOAD (1 cycle), register the origin, colour and erase flag, and clear the pixel counters; plot=0 and ready=0.
REQ-017 SHALL, in DRAW, assert plot=1 every cycle for exactly TILE_SIZE*TILE_SIZE cycles, scanning row-major: local x increments each cycle, wraps to 0 at TILE_SIZE-1, and local y then increments.
REQ-018 SHALL drive x = origin x + local x and y = origin y + local y, registered in the same cycle as plot.
REQ-019 SHALL transition DRAW->DONE after the pixel at local (TILE_SIZE-1, TILE_SIZE-1); DONE lasts 1 cycle with done=1, plot=0 and ready=0, then goes to IDLE.
REQ-020 SHALL give a total latency of TILE_SIZE^2+2 cycles from start acceptance to the done pulse; the next start is accepted no earlier than the cycle after done.
REQ-021 SHALL ignore start while ready=0, and SHALL ignore tile/erase changes after acceptance.
REQ-022 SHALL drive colour 3'b000 on every plotted pixel when the latched erase flag is 1.
REQ-023 SHALL hold x, y and colour at their last values whenever plot=0.

Reset
REQ-024 SHALL, when reset=1, put the FSM in IDLE at the next edge with ready=1, plot=0, done=0, x=0, y=0, colour=0 and counters=0.
REQ-025 SHALL, on reset asserted mid-DRAW, abort the draw with no done pulse; plot SHALL be 0 from the cycle after the reset edge.
REQ-026 SHALL give reset priority over start when both are asserted in the same cycle.

Configuration
REQ-027 SHALL use macro TILE_BORDER_EN: when defined and erase=0, pixels with local x or local y equal to 0 or TILE_SIZE-1 are drawn 3'b111 and interior pixels use the tile colour.
REQ-028 SHALL, without TILE_BORDER_EN, draw every pixel in the tile colour (or black when erasing); cycle timing is identical in both builds.

Structure
REQ-029 SHALL place TILE_SIZE, the FSM state encoding, and the colour constants (BLACK, WHITE, four tile colours) in shared package tile_pkg.
REQ-030 SHALL implement the index-to-origin/colour mapping as combinational sub-module tile_origin_lut, instantiated once.

Verification
REQ-031 SHALL cover: start with tile=0, erase=0 -> 64 plot pulses over x 0..7, y 0..7, colour 001, then done exactly at cycle 66.
REQ-032 SHALL cover: tile=3 -> first pixel (8,8), last pixel (15,15), colour 100.
REQ-033 SHALL cover: tile=1, erase=1 -> 64 pixels at x 8..15, y 0..7, all colour 000.
REQ-034 SHALL cover: start pulsed again during DRAW with tile=2 -> ignored; pixels stay on tile 1 and there is exactly one done.
REQ-035 SHALL cover: reset at DRAW pixel 20 -> plot=0 next cycle, no done, ready=1; a new start draws all 64 pixels.
REQ-036 SHALL cover: with TILE_BORDER_EN, tile=2 -> (0,8) and (7,15) are 111, (3,11) is 011; pixel count is still 64.
